r5p_degu_tcb_responder: RTL

Synthesizable TCB subordinate that terminates an IFU or LSU bus of the R5P-degu core with a byte-addressed memory and fixed-latency responses. It is the responder end of the interface the execution trace logger monitors; the logger samples request fields at the transfer edge and read data one cycle later, so the default latency is 1. Optional pseudo-random backpressure exercises core stall paths. Transfer counters expose bus activity for statistics.

---
 rtl/r5p_degu_tcb_responder_if.sv | 26 ++
 rtl/r5p_degu_tcb_responder.sv | 94 +++++++++
 2 files changed

// File: rtl/r5p_degu_tcb_responder_if.sv
// rtl/r5p_degu_tcb_responder_if.sv - TCB request/response bus with manager and subordinate views
interface tcb_if;
    typedef struct packed {
        logic        wen;
        logic [31:0] adr;
        logic [3:0]  ben;
        logic [31:0] wdt;
    } tcb_req_t;

    typedef struct packed {
        logic err;
    } tcb_sts_t;

    typedef struct packed {
        logic [31:0] rdt;
        tcb_sts_t    sts;
    } tcb_rsp_t;

    logic     vld;
    tcb_req_t req;
    logic     rdy;
    tcb_rsp_t rsp;

    modport man (output vld, output req, input rdy, input rsp);
    modport sub (input vld, input req, output rdy, output rsp);
endinterface

// File: rtl/r5p_degu_tcb_responder.sv
// rtl/r5p_degu_tcb_responder.sv - TCB subordinate memory with fixed-latency responses and optional stalls
module r5p_degu_tcb_responder #(
    parameter int unsigned DBW  = 32,
    parameter int unsigned MSZ  = 16384,
    parameter int unsigned DLY  = 1,
    parameter int unsigned STL  = 0,
    parameter int unsigned MAX  = 3,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    tcb_if.sub          tcb,
    output logic [31:0] cnt_rd,
    output logic [31:0] cnt_wr
);
    localparam int unsigned AW  = $clog2(MSZ);
    localparam int unsigned WN  = MSZ / 4;
    localparam int unsigned SCW = (MAX > 0) ? $clog2(MAX + 1) : 1;

    logic              trn;
    logic              in_rng;
    logic [AW-3:0]     idx;
    logic [DBW-1:0]    rd_word;
    logic              err0;
    logic              run;
    logic              rdy;
    logic [15:0]       lfsr;
    logic [SCW-1:0]    stall_cnt;
    logic [DBW-1:0]    mem      [WN];
    logic [DBW-1:0]    rdt_pipe [DLY];
    logic              err_pipe [DLY];

    assign in_rng = (tcb.req.adr < 32'(MSZ));
    assign idx    = tcb.req.adr[AW-1:2];
    assign trn    = tcb.vld & rdy;

    // run holds rdy low until the first edge after reset release
    assign rdy     = run & ((STL == 0) | lfsr[0] | (stall_cnt == SCW'(MAX)));
    assign tcb.rdy = rdy;

    assign rd_word = (trn && !tcb.req.wen && in_rng) ? mem[idx] : '0;
    assign err0    = trn & ~in_rng;

    always_ff @(posedge clk) begin
        if (trn && tcb.req.wen && in_rng) begin
            for (int i = 0; i < 4; i++) begin
                if (tcb.req.ben[i]) mem[idx][8*i +: 8] <= tcb.req.wdt[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run       <= 1'b0;
            lfsr      <= SEED;
            stall_cnt <= '0;
        end else begin
            run <= 1'b1;
            if (run) begin
                // Fibonacci taps 16,14,13,11 in right-shift form
                lfsr      <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
                stall_cnt <= rdy ? '0 : stall_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DLY; i++) begin
                rdt_pipe[i] <= '0;
                err_pipe[i] <= 1'b0;
            end
        end else begin
            rdt_pipe[0] <= rd_word;
            err_pipe[0] <= err0;
            for (int i = 1; i < DLY; i++) begin
                rdt_pipe[i] <= rdt_pipe[i-1];
                err_pipe[i] <= err_pipe[i-1];
            end
        end
    end

    assign tcb.rsp = {rdt_pipe[DLY-1], err_pipe[DLY-1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_rd <= '0;
            cnt_wr <= '0;
        end else if (trn) begin
            if (tcb.req.wen) cnt_wr <= cnt_wr + 1'b1;
            else             cnt_rd <= cnt_rd + 1'b1;
        end
    end
endmodule
